// File: rtl/armleo_arb_pkg.sv
// Shared types and sizing helpers for the armleo arbiter family.
// Pure declarations; no logic, no latency, no flow control.
package armleo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    function automatic int arb_idx_w(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/armleo_rr_pick.sv
// Rotating priority pick: first set bit of req searching upward from ptr, wrapping.
// Purely combinational; no backpressure.
module armleo_rr_pick
    import armleo_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = arb_idx_w(WIDTH)
)(
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cidx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        sum    = '0;
        cidx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(WIDTH)) begin
                sum = sum - (IDX_W + 1)'(WIDTH);
            end
            cidx = sum[IDX_W-1:0];
            if (req[cidx]) begin
                found  = 1'b1;
                idx    = cidx;
                onehot = WIDTH'(1) << cidx;
            end
        end
    end

endmodule

// File: rtl/armleo_wrr_arbiter.sv
// Weighted round-robin arbiter, packet-atomic, registered grant 1 cycle after request; no bubble on handover.
// Beats move on grant_valid & grant_ready; ARMLEO_WRR_STATS_EN adds per-requester packet counters.
module armleo_wrr_arbiter
    import armleo_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int WEIGHT_W = 4
`ifdef ARMLEO_WRR_STATS_EN
    ,parameter int STATS_W = 16
`endif
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              request,
    input  logic [WIDTH*WEIGHT_W-1:0]     weight,
    output logic [WIDTH-1:0]              grant,
    output logic [arb_idx_w(WIDTH)-1:0]   grant_idx,
    output logic                          grant_valid,
    input  logic                          grant_ready,
    input  logic                          last
`ifdef ARMLEO_WRR_STATS_EN
    ,output logic [WIDTH*STATS_W-1:0]     pkt_count
`endif
);

    localparam int IDX_W = arb_idx_w(WIDTH);

    arb_state_t          state_q;
    logic [WIDTH-1:0]    grant_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    ptr_q;
    logic [IDX_W-1:0]    ptr_d;
    logic [IDX_W-1:0]    pick_ptr;
    logic [WEIGHT_W-1:0] quota_q;
    logic                in_pkt_q;

    logic                beat;
    logic                rel_pkt;
    logic                rel_idle;
    logic                release_w;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [WIDTH-1:0]    pick_onehot;
    logic [WEIGHT_W-1:0] win_weight;
    logic [WEIGHT_W-1:0] quota_init;

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = |grant_q;

    assign beat      = grant_valid & grant_ready;
    assign rel_pkt   = beat & last & (quota_q == WEIGHT_W'(1));
    assign rel_idle  = ~in_pkt_q & ~request[idx_q];
    assign release_w = (state_q == ARB_GRANT) & (rel_pkt | rel_idle);

    assign ptr_d    = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
    // While granted the picker looks ahead from the post-release pointer.
    assign pick_ptr = (state_q == ARB_GRANT) ? ptr_d : ptr_q;

    armleo_rr_pick #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (request),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign win_weight = weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
    assign quota_init = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            quota_q  <= '0;
            in_pkt_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state_q  <= ARB_GRANT;
                        grant_q  <= pick_onehot;
                        idx_q    <= pick_idx;
                        quota_q  <= quota_init;
                        in_pkt_q <= 1'b0;
                    end
                end
                ARB_GRANT: begin
                    if (beat) begin
                        in_pkt_q <= ~last;
                        if (last) begin
                            quota_q <= quota_q - WEIGHT_W'(1);
                        end
                    end
                    if (release_w) begin
                        ptr_q    <= ptr_d;
                        in_pkt_q <= 1'b0;
                        if (pick_found) begin
                            grant_q <= pick_onehot;
                            idx_q   <= pick_idx;
                            quota_q <= quota_init;
                        end else begin
                            state_q <= ARB_IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

`ifdef ARMLEO_WRR_STATS_EN
    logic [STATS_W-1:0] cnt_q [WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (beat && last) begin
            cnt_q[idx_q] <= cnt_q[idx_q] + STATS_W'(1);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
        assign pkt_count[g*STATS_W +: STATS_W] = cnt_q[g];
    end
`endif

endmodule
